// File: rtl/mem_cycle_sequencer.sv
// mem_cycle_sequencer
// Turns a one-cycle memory request into a timed bus cycle: address/data
// setup, a wr or rd strobe of fixed length, then a hold period. The wr/rd
// outputs feed an external strobe register that generates notWR/notRD on the
// following falling edge. The block also holds address and write data on the
// bus, captures read data at the end of the strobe, and reports busy/done.
module mem_cycle_sequencer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  req,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done
);

  // Bus cycle phases
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Zero-length setup/hold phases are skipped entirely rather than visited
  // for one cycle, so these flags select the shortcut transitions.
  localparam bit HAS_SETUP = (SETUP_CYCLES > 0);
  localparam bit HAS_HOLD  = (HOLD_CYCLES > 0);

  // The down-counter is loaded with (length - 1) on entry to a phase and the
  // phase ends on the edge where it reads zero, so a phase of N cycles spans
  // exactly N clock edges. Eight bits cover lengths up to 255.
  localparam logic [7:0] SETUP_LOAD  = 8'(HAS_SETUP ? SETUP_CYCLES - 1 : 0);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HAS_HOLD ? HOLD_CYCLES - 1 : 0);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [7:0] count;
  logic [7:0] next_count;
  logic       write_q;

  logic       count_zero;
  logic       start;
  logic       enter_strobe;
  logic       strobe_end;
  logic       finish;
  logic       strobe_write;

  // Decode the edge events that drive the output registers
  always_comb begin
    count_zero   = (count == 8'd0);
    start        = (state == IDLE) && req;
    enter_strobe = (start && !HAS_SETUP) || ((state == SETUP) && count_zero);
    strobe_end   = (state == STROBE) && count_zero;
    finish       = (strobe_end && !HAS_HOLD) || ((state == HOLD) && count_zero);
    strobe_write = start ? write : write_q;
  end

  // Next phase and counter reload on each phase entry
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (req) begin
          if (HAS_SETUP) begin
            next_state = SETUP;
            next_count = SETUP_LOAD;
          end else begin
            next_state = STROBE;
            next_count = STROBE_LOAD;
          end
        end
      end
      SETUP: begin
        if (count_zero) begin
          next_state = STROBE;
          next_count = STROBE_LOAD;
        end else begin
          next_count = count - 8'd1;
        end
      end
      STROBE: begin
        if (count_zero) begin
          if (HAS_HOLD) begin
            next_state = HOLD;
            next_count = HOLD_LOAD;
          end else begin
            next_state = IDLE;
            next_count = 8'd0;
          end
        end else begin
          next_count = count - 8'd1;
        end
      end
      HOLD: begin
        if (count_zero) begin
          next_state = IDLE;
          next_count = 8'd0;
        end else begin
          next_count = count - 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = 8'd0;
      end
    endcase
  end

  // Phase register and down-counter
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Request capture: address, write data and direction are frozen for the
  // whole bus cycle and simply left in place once it completes
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      addr_out <= '0;
      data_out <= '0;
      write_q  <= 1'b0;
    end else if (start) begin
      addr_out <= addr_in;
      data_out <= wdata;
      write_q  <= write;
    end
  end

  // Strobe generation: exactly one of wr/rd is raised for the strobe phase
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wr <= 1'b0;
      rd <= 1'b0;
    end else if (enter_strobe) begin
      wr <= strobe_write;
      rd <= ~strobe_write;
    end else if (strobe_end) begin
      wr <= 1'b0;
      rd <= 1'b0;
    end
  end

  // Read data is sampled on the edge that ends the strobe; writes leave it
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      rdata <= '0;
    end else if (strobe_end && !write_q) begin
      rdata <= data_in;
    end
  end

  // Status back to the control unit and the write-data bus enable
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      done <= finish;
      if (start) begin
        busy    <= 1'b1;
        data_oe <= write;
      end else if (finish) begin
        busy    <= 1'b0;
        data_oe <= 1'b0;
      end
    end
  end

endmodule
